// File: rtl/mem_rr_sched.sv
// mem_rr_sched: round-robin arbiter sharing one SDRAM request port among N clients.
// Define MEM_RR_SCHED_PRI0_EN to give client 0 fixed top priority over the rotation.
module mem_rr_sched #(
  parameter int AN      = 24,
  parameter int DN      = 16,
  parameter int N       = 4,
  parameter int IDN     = $clog2(N),
  parameter int TIMEOUT = 1023
) (
  input  logic            clkSYS,
  input  logic            reset,
  input  logic [N-1:0]    c_req,
  input  logic [N-1:0]    c_wr,
  input  logic [N*AN-1:0] c_addr,
  input  logic [N*DN-1:0] c_data,
  output logic [N-1:0]    c_ack,
  output logic [N-1:0]    c_valid,
  output logic [DN-1:0]   c_mem,
  output logic            m_req,
  output logic            m_wr,
  output logic [AN-1:0]   m_addr,
  output logic [DN-1:0]   m_data,
  output logic [IDN-1:0]  m_id,
  input  logic            m_ack,
  input  logic            m_valid,
  input  logic [DN-1:0]   m_mem,
  input  logic [IDN-1:0]  m_rid,
  output logic            timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t         state_q;
  logic [IDN-1:0] last_q;
  logic [IDN-1:0] last_d;
  logic [CW-1:0]  cnt_q;
  logic [IDN-1:0] win;
  logic           found;
  int             idx;

  // Scan downwards so the nearest requester after last_q overwrites the rest.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N;
      if (c_req[idx]) begin
        win   = IDN'(idx);
        found = 1'b1;
      end
    end
`ifdef MEM_RR_SCHED_PRI0_EN
    if (c_req[0]) begin
      win   = '0;
      found = 1'b1;
    end
`endif
  end

  always_comb begin
`ifdef MEM_RR_SCHED_PRI0_EN
    last_d = (m_id == '0) ? last_q : m_id;
`else
    last_d = m_id;
`endif
  end

  assign c_ack = (m_ack && state_q == BUSY)
               ? ({{(N-1){1'b0}}, 1'b1} << m_id)
               : '0;

  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDN'(N - 1);
      cnt_q   <= '0;
      m_req   <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      m_id    <= '0;
      timeout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            m_req   <= 1'b1;
            m_wr    <= c_wr[win];
            m_addr  <= c_addr[int'(win)*AN +: AN];
            m_data  <= c_data[int'(win)*DN +: DN];
            m_id    <= win;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (m_ack) begin
            m_req   <= 1'b0;
            last_q  <= last_d;
            state_q <= IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            m_req   <= 1'b0;
            timeout <= 1'b1;
            last_q  <= last_d;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read return is tag-routed and runs independently of the grant FSM.
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      c_valid <= '0;
      c_mem   <= '0;
    end else begin
      if (m_valid && int'(m_rid) < N) begin
        c_valid <= {{(N-1){1'b0}}, 1'b1} << m_rid;
      end else begin
        c_valid <= '0;
      end
      if (m_valid) begin
        c_mem <= m_mem;
      end
    end
  end

endmodule
